// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RV32I datapath.
package riscv_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned MEM_WORDS_DEFAULT = 32;

    // Fetch stage states. HALT is terminal until reset.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // An all-zero instruction word stops the fetch stage.
    localparam logic [XLEN-1:0] INSTR_ZERO = '0;

    // Sequential successor of a byte address (wraps at 2^32).
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_addr_sel.sv
// Instruction-memory address select and fetch legality check.
// Purely combinational; all state lives in fetch_unit.
module fetch_addr_sel
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic            halted_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic            if_valid_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic [XLEN-1:0] addr_o,
    output logic            legal_o
);

    // One past the last legal byte address.
    localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(MEM_WORDS * 4);

    // Priority: halted, replay on stall, branch redirect, sequential pc.
    always_comb begin
        addr_o = pc_i;
        if (halted_i) begin
            addr_o = if_pc_i;
        end else if (stall_i && if_valid_i) begin
            addr_o = if_pc_i;
        end else if (branch_taken_i && if_valid_i) begin
            addr_o = branch_target_i;
        end
    end

    // A fetch is legal when word-aligned and inside instruction memory.
    always_comb begin
        legal_o = (addr_o < ADDR_LIMIT) && (addr_o[1:0] == 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address, and presents fetched words to decode with a valid flag.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_instr,
    output logic [XLEN-1:0]  if_instr,
    output logic [XLEN-1:0]  if_pc,
    output logic             if_valid,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  if_pc_q, if_pc_d;
    logic             if_valid_q, if_valid_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             addr_legal;

    fetch_addr_sel #(
        .MEM_WORDS(MEM_WORDS)
    ) u_addr_sel (
        .halted_i       (state_q == HALT),
        .stall_i        (stall),
        .branch_taken_i (branch_taken),
        .if_valid_i     (if_valid_q),
        .branch_target_i(branch_target),
        .pc_i           (pc_q),
        .if_pc_i        (if_pc_q),
        .addr_o         (imem_addr),
        .legal_o        (addr_legal)
    );

    // State and fetch registers; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next state: halt on zero word or illegal address, else fetch; a stall
    // or HALT holds everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        if (state_q == RUN && !stall) begin
            if (if_valid_q && imem_instr == INSTR_ZERO) begin
                state_d    = HALT;
                if_valid_d = 1'b0;
            end else if (!addr_legal) begin
                state_d    = HALT;
                fault_d    = 1'b1;
                if_valid_d = 1'b0;
            end else begin
                if_pc_d    = imem_addr;
                if_valid_d = 1'b1;
                pc_d       = next_pc(imem_addr);
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign if_instr    = imem_instr;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign halted      = (state_q == HALT);
    assign fault       = fault_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous instruction memory, directed scenarios
// with literal expectations, then randomized stall/branch/reset traffic
// checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam int unsigned MEM_WORDS = 32;
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_instr;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc;
    logic             if_valid;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [MEM_WORDS];

    // Model state: what decode should observe, derived from the fetch rules.
    logic             live = 1'b0;
    logic [31:0]      m_pc, m_if_pc, m_a;
    logic             m_valid, m_halted, m_fault;
    logic [CNT_W-1:0] m_cnt;

    fetch_unit #(
        .MEM_WORDS(MEM_WORDS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_valid     (if_valid),
        .halted       (halted),
        .fault        (fault),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-edge read latency, word indexed.
    always @(posedge clk) imem_instr <= prog[imem_addr[6:2]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Address the fetch stage must present this cycle.
    function automatic logic [31:0] exp_addr();
        if (m_halted) return m_if_pc;
        if (stall && m_valid) return m_if_pc;
        if (branch_taken && m_valid) return branch_target;
        return m_pc;
    endfunction

    // Reference model advance.
    always @(posedge clk) begin
        m_a = exp_addr();
        if (reset) begin
            m_pc <= 0; m_if_pc <= 0; m_valid <= 0;
            m_halted <= 0; m_fault <= 0; m_cnt <= 0;
            live <= 1'b1;
        end else if (live && !m_halted && !stall) begin
            if (m_valid && prog[m_if_pc[6:2]] == 32'd0) begin
                m_halted <= 1; m_valid <= 0;
            end else if (m_a >= MEM_WORDS * 4 || m_a[1:0] != 2'b00) begin
                m_halted <= 1; m_fault <= 1; m_valid <= 0;
            end else begin
                m_if_pc <= m_a;
                m_valid <= 1;
                m_pc    <= m_a + 32'd4;
                if (m_cnt != CNT_MAX) m_cnt <= m_cnt + 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("imem_addr", imem_addr, exp_addr());
            chk("if_pc", if_pc, m_if_pc);
            chk("if_valid", 32'(if_valid), 32'(m_valid));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("fault", 32'(fault), 32'(m_fault));
            chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
            if (m_valid) chk("if_instr", if_instr, prog[m_if_pc[6:2]]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rst();
        reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
        tick();
        reset = 0;
    endtask

    task automatic pin(input string nm, input logic [31:0] pc, input logic v,
                       input logic h, input logic f, input logic [31:0] cnt);
        chk({nm, ".if_pc"}, if_pc, pc);
        chk({nm, ".if_valid"}, 32'(if_valid), 32'(v));
        chk({nm, ".halted"}, 32'(halted), 32'(h));
        chk({nm, ".fault"}, 32'(fault), 32'(f));
        chk({nm, ".count"}, 32'(fetch_count), cnt);
    endtask

    logic st_prev;
    int   r;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) prog[i] = 32'h0010_0093 + 32'(i);
        prog[11] = 32'd0;
        reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
        ticks(2);
        pin("reset", 0, 0, 0, 0, 0);
        chk("reset.imem_addr", imem_addr, 0);

        // Free run: five sequential words.
        reset = 0;
        ticks(5);
        pin("run5", 16, 1, 0, 0, 5);

        // Zero-bubble branch 24 -> 36.
        rst(); ticks(7);
        pin("pre_br", 24, 1, 0, 0, 7);
        branch_taken = 1; branch_target = 36;
        tick();
        pin("br36", 36, 1, 0, 0, 8);
        branch_taken = 0;
        tick();
        pin("after_br", 40, 1, 0, 0, 9);

        // Two-cycle stall at 8, then stall overriding a branch at 12.
        rst(); ticks(3);
        stall = 1;
        tick();
        pin("stall1", 8, 1, 0, 0, 3);
        chk("stall1.instr", if_instr, 32'h0010_0095);
        tick();
        pin("stall2", 8, 1, 0, 0, 3);
        chk("stall2.instr", if_instr, 32'h0010_0095);
        stall = 0;
        tick();
        pin("resume", 12, 1, 0, 0, 4);
        stall = 1; branch_taken = 1; branch_target = 64;
        tick();
        pin("stall_vs_br", 12, 1, 0, 0, 4);
        stall = 0;
        tick();
        pin("br_after_stall", 64, 1, 0, 0, 5);
        branch_taken = 0;

        // Zero word at 44 halts cleanly and stays halted.
        rst(); ticks(12);
        pin("word11", 44, 1, 0, 0, 12);
        chk("word11.instr", if_instr, 0);
        tick();
        pin("zhalt", 44, 0, 1, 0, 12);
        ticks(12);
        pin("zhalt_hold", 44, 0, 1, 0, 12);
        chk("zhalt.imem_addr", imem_addr, 44);

        // Out-of-range branch target.
        rst(); ticks(2);
        branch_taken = 1; branch_target = 128;
        tick();
        pin("fault128", 4, 0, 1, 1, 2);
        branch_taken = 0;

        // Misaligned branch target, then reset out of HALT.
        rst(); ticks(1);
        branch_taken = 1; branch_target = 32'h22;
        tick();
        pin("fault22", 0, 0, 1, 1, 1);
        branch_taken = 0; reset = 1;
        tick();
        pin("rst_halt", 0, 0, 0, 0, 0);
        chk("rst_halt.imem_addr", imem_addr, 0);
        reset = 0;
        tick();
        pin("first_after_halt", 0, 1, 0, 0, 1);

        // Reset while stalled at 20.
        rst(); ticks(6);
        stall = 1;
        tick();
        pin("stall20", 20, 1, 0, 0, 6);
        reset = 1;
        tick();
        pin("rst_stall", 0, 0, 0, 0, 0);
        reset = 0; stall = 0;
        tick();
        pin("first_after_stall", 0, 1, 0, 0, 1);

        // Counter saturation: keep branching to word 0.
        rst();
        branch_taken = 1; branch_target = 0;
        ticks(20);
        pin("saturate", 0, 1, 0, 0, 32'(CNT_MAX));
        branch_taken = 0;

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if (reset) begin
                reset = 0;
            end else if (c == 0 || (m_halted && $urandom_range(0, 3) == 0) ||
                         $urandom_range(0, 299) == 0) begin
                reset = 1; stall = 0; branch_taken = 0;
                tick();
                for (int i = 0; i < MEM_WORDS; i++)
                    prog[i] = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom | 32'd1);
                continue;
            end
            st_prev = stall;
            stall = ($urandom_range(0, 3) == 0);
            if (!st_prev) begin
                branch_taken = ($urandom_range(0, 3) == 0);
                r = $urandom_range(0, 19);
                if (r < 18)       branch_target = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
                else if (r == 18) branch_target = MEM_WORDS * 4 + 32'($urandom_range(0, 64)) * 4;
                else              branch_target = 32'($urandom_range(0, MEM_WORDS - 1)) * 4
                                                  + 32'($urandom_range(1, 3));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-cycle RV32I datapath (add/sub/and/or/lw/sw/beq). Owns the program counter, drives the word address of the instruction memory (synchronous read, one-cycle latency, indexed by address/4), and presents the fetched instruction with its PC and a valid flag to decode. Handles decode stalls, taken-branch redirects, halting on an all-zero word, and fault stops on illegal fetch addresses.

## Interface
- MEM_WORDS, 32: instruction memory depth in words; legal fetch byte addresses are 0 .. MEM_WORDS*4-4.
- CNT_W, 16: width of fetch_count.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  decode cannot accept; hold current instruction
- branch_taken  in  1  redirect to branch_target; sampled only when if_valid=1
- branch_target  in  32  byte address of the branch destination
- imem_addr  out  32  byte address to instruction memory (combinational select)
- imem_instr  in  32  memory read data, valid one edge after imem_addr
- if_instr  out  32  instruction to decode (= imem_instr)
- if_pc  out  32  byte address of if_instr
- if_valid  out  1  if_instr/if_pc are a live fetch
- halted  out  1  fetch stopped (zero word or fault)
- fault  out  1  stop caused by illegal address
- fetch_count  out  CNT_W  number of fetches delivered, saturating

## Operation
- States: RUN, HALT. Reset enters RUN with pc_q=0. HALT exits only by reset.
- Reset values: pc_q=0, if_pc=0, if_valid=0, halted=0, fault=0, fetch_count=0, state=RUN.
- imem_addr select, in priority order: HALT -> if_pc; stall && if_valid -> if_pc (replay, so memory re-reads the same word); branch_taken && if_valid -> branch_target; else pc_q.
- RUN, each edge, not stalled:
  - if if_valid && if_instr==0 -> HALT, halted=1, if_valid=0, no fetch.
  - else if imem_addr >= MEM_WORDS*4 or imem_addr[1:0]!=0 -> HALT, halted=1, fault=1, if_valid=0.
  - else fetch: if_pc<=imem_addr, if_valid<=1, pc_q<=imem_addr+4 (32-bit wrap), fetch_count+=1 (saturates at all-ones).
- Stalled edge: if_pc, if_valid, pc_q, fetch_count unchanged. Memory re-reads if_pc, so if_instr is stable.
- stall and branch_taken in the same cycle: stall wins. Decode must hold branch_taken/branch_target until the stall clears.
- Zero-word check happens only when the word is not stalled. A stalled zero word halts on the first unstalled edge.

## Timing
- Fetch latency: 1 edge from imem_addr to if_instr/if_pc/if_valid.
- First edge with reset low: word 0 fetched. After it: if_pc=0, if_valid=1.
- Branch: zero-bubble. The target is fetched on the edge that samples branch_taken, and no squash is needed.
- Throughput: 1 instruction per cycle absent stalls.
- Reset mid-operation: all state returns to reset values at that edge, regardless of state or stall.
- HALT: outputs frozen, if_valid=0, imem_addr=if_pc.

## Structure
- Shared package riscv_pkg: XLEN=32, MEM_WORDS default, fetch_state_t enum {RUN, HALT}, INSTR_ZERO constant.
- One natural combinational sub-module, fetch_addr_sel: implements the imem_addr priority mux and the legality check (range/alignment). The state, pc_q and counters live in fetch_unit.

## Test plan
- Reset, then 5 free-running edges with the default program: if_pc = 0, 4, 8, 12, 16; if_valid=1; fetch_count=5.
- beq at if_pc=24 with branch_taken=1 and target=36: next if_pc=36, no bubble; fetch_count increments by 1.
- stall=1 for 2 cycles at if_pc=8: if_pc=8 and if_instr unchanged for both cycles; fetch_count unchanged; resumes at 12.
- Run to word 11 (zero): after that word is presented unstalled, next edge gives halted=1, fault=0, if_valid=0; state holds for 10+ cycles.
- Branch to 128 (MEM_WORDS=32): halted=1, fault=1. Separate run with target 0x22: halted=1, fault=1.
- Reset asserted during stall at if_pc=20 and during HALT: next edge gives all outputs at reset values; first fetch after release is word 0.
